// File: rtl/wb_burst_pkg.sv
// rtl/wb_burst_pkg.sv - FSM state type and Wishbone cycle-type constants for wb_burst_master
package wb_burst_pkg;

  typedef enum logic [1:0] {IDLE, BURST, STALL, FINISH} state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam int         TIMEOUT_LIMIT = 255;

endpackage

// File: rtl/wishbone_b3.sv
// rtl/wishbone_b3.sv - Wishbone B3 signal bundle with master and slave modports
interface wishbone_b3 #(
  parameter int data_width = 32,
  parameter int addr_width = 8
) ();
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [addr_width-1:0]   adr;
  logic [data_width/8-1:0] sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [data_width-1:0]   dat_m2s;
  logic [data_width-1:0]   dat_s2m;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (output cyc, stb, we, adr, sel, cti, bte, dat_m2s,
                  input  dat_s2m, ack, err, rty);
  modport slave  (input  cyc, stb, we, adr, sel, cti, bte, dat_m2s,
                  output dat_s2m, ack, err, rty);
endinterface

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - command-driven Wishbone B3 incrementing-burst master
// Optional ack watchdog: define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 8,
  parameter int max_burst  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  wishbone_b3.master                   bus,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [addr_width-1:0]        cmd_addr,
  input  logic [$clog2(max_burst)-1:0] cmd_len,
  input  logic [data_width-1:0]        wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [data_width-1:0]        rd_data,
  output logic                         rd_valid,
  output logic                         done,
  output logic                         error
);

  localparam int                    lw    = $clog2(max_burst);
  localparam logic [addr_width-1:0] step  = addr_width'(data_width / 8);
  localparam logic [addr_width-1:0] amask = addr_width'(data_width / 8 - 1);

  state_t                state;
  logic                  cyc_r;
  logic                  stb_en;
  logic                  we_r;
  logic [addr_width-1:0] adr_r;
  logic [2:0]            cti_r;
  logic [lw-1:0]         cnt;
  logic                  ack_ok;
  logic                  beat;
  logic                  abort;
  logic                  timeout;

  // Write strobes follow the data stream directly so stb is low in exactly the starved cycles.
  assign bus.stb     = stb_en & (~we_r | wr_valid);
  assign bus.cyc     = cyc_r;
  assign bus.we      = we_r;
  assign bus.adr     = adr_r;
  assign bus.cti     = cti_r;
  assign bus.sel     = '1;
  assign bus.bte     = BTE_LINEAR;
  assign bus.dat_m2s = wr_data;

  // ack together with rty is illegal on the bus; the retry wins and the beat waits.
  assign ack_ok    = bus.ack & ~bus.rty;
  assign beat      = bus.stb & ack_ok & ~bus.err;
  assign abort     = (bus.stb & bus.err) | timeout;
  assign wr_ready  = beat & we_r;
  assign cmd_ready = (state == IDLE);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  logic [7:0] wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wd <= '0;
    else if (bus.stb & ~ack_ok)
      wd <= wd + 8'd1;
    else
      wd <= '0;
  end

  assign timeout = bus.stb & ~ack_ok & (wd == 8'(TIMEOUT_LIMIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cyc_r    <= 1'b0;
      stb_en   <= 1'b0;
      we_r     <= 1'b0;
      adr_r    <= '0;
      cti_r    <= CTI_CLASSIC;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cyc_r  <= 1'b1;
            stb_en <= 1'b1;
            we_r   <= cmd_we;
            adr_r  <= cmd_addr & ~amask;
            cnt    <= cmd_len;
            cti_r  <= (cmd_len == '0) ? CTI_EOB : CTI_INCR;
            state  <= (cmd_we & ~wr_valid) ? STALL : BURST;
          end
        end
        BURST, STALL: begin
          if (abort) begin
            cyc_r  <= 1'b0;
            stb_en <= 1'b0;
            we_r   <= 1'b0;
            cti_r  <= CTI_CLASSIC;
            done   <= 1'b1;
            error  <= 1'b1;
            state  <= FINISH;
          end else if (beat) begin
            adr_r <= adr_r + step;
            if (!we_r) begin
              rd_data  <= bus.dat_s2m;
              rd_valid <= 1'b1;
            end
            if (cnt == '0) begin
              cyc_r  <= 1'b0;
              stb_en <= 1'b0;
              we_r   <= 1'b0;
              cti_r  <= CTI_CLASSIC;
              done   <= 1'b1;
              state  <= FINISH;
            end else begin
              cnt   <= cnt - lw'(1);
              cti_r <= (cnt == lw'(1)) ? CTI_EOB : CTI_INCR;
              state <= BURST;
            end
          end else begin
            state <= (we_r & ~wr_valid) ? STALL : BURST;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - self-checking bench for wb_burst_master with a behavioural RAM slave
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wishbone_b3 #(.data_width(32), .addr_width(8)) bus_if ();

  wb_burst_master #(.data_width(32), .addr_width(8), .max_burst(8)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error)
  );

  // Behavioural RAM slave: combinational ack/err/rty, writes land on the acked edge.
  logic [31:0] ram [64];
  logic [31:0] model [64];
  logic        ack_en, err_en, pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_dat;

  assign bus_if.ack     = bus_if.cyc & bus_if.stb & ack_en & ~err_en;
  assign bus_if.err     = bus_if.cyc & bus_if.stb & err_en;
  assign bus_if.rty     = bus_if.cyc & bus_if.stb & ~ack_en & ~err_en;
  assign bus_if.dat_s2m = ram[bus_if.adr[7:2]];

  always @(posedge clk) begin
    if (pre_we)
      ram[pre_idx] <= pre_dat;
    else if (bus_if.cyc && bus_if.stb && bus_if.ack && bus_if.we)
      ram[bus_if.adr[7:2]] <= bus_if.dat_m2s;
  end

  logic [31:0] last_rd;
  int          last_stb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = 6'(idx);
    pre_dat = val;
    model[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One command end to end; expectations come from the address/cti/data rules applied to the model.
  task automatic run_cmd(input string tag, input bit we, input logic [7:0] addr, input int len,
                         input int gap_after, input int gap_cycles, input int err_beat, input int ack_pct);
    int          n;
    int          exp_beats;
    bit          exp_err;
    int          beats, rds, wrs, dones, errs, stbc, gap_left, extra, diffs;
    int          adr_bad, cti_bad, rd_bad, gap_bad, cyc_bad, ready_bad;
    bit          in_gap;
    logic [7:0]  base, exp_a;
    logic [31:0] e;
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    n = len + 1;
    exp_beats = (err_beat >= 0) ? err_beat : n;
    exp_err = (err_beat >= 0) || (ack_pct == 0);
    if (ack_pct == 0) exp_beats = 0;
    beats = 0; rds = 0; wrs = 0; dones = 0; errs = 0; stbc = 0; extra = 0; diffs = 0;
    adr_bad = 0; cti_bad = 0; rd_bad = 0; gap_bad = 0; cyc_bad = 0; ready_bad = 0;
    gap_left = gap_cycles;
    base = addr & 8'hFC;
    for (int i = 0; i < n; i++) wq.push_back($urandom);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = 3'(len);
    wr_valid = we; wr_data = wq[0]; err_en = 1'b0; ack_en = 1'b1;
    #1;
    check({tag, " accept_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      in_gap = 1'b0;
      if (we && gap_after > 0 && beats == gap_after && gap_left > 0) begin
        in_gap = 1'b1;
        gap_left--;
        wr_valid = 1'b0;
      end else begin
        wr_valid = we && (beats < n);
        wr_data  = (beats < n) ? wq[beats] : 32'h0;
      end
      err_en = (beats == err_beat);
      ack_en = ($urandom_range(0, 99) < ack_pct);
      #1;
      if (in_gap && !(bus_if.cyc && !bus_if.stb)) gap_bad++;
      if (!in_gap && bus_if.cyc && !bus_if.stb) gap_bad++;
      if (cmd_ready && bus_if.cyc) ready_bad++;
      if (bus_if.stb) stbc++;
      if (rd_valid) begin
        rds++;
        last_rd = rd_data;
        if (rq.size() == 0) rd_bad++;
        else begin
          e = rq.pop_front();
          if (rd_data !== e) rd_bad++;
        end
      end
      if (wr_ready) wrs++;
      if (bus_if.cyc && bus_if.stb && bus_if.ack) begin
        exp_a = base + 8'(beats * 4);
        if (bus_if.adr !== exp_a) adr_bad++;
        if (bus_if.cti !== ((beats == n - 1) ? 3'b111 : 3'b010)) cti_bad++;
        if (!we) rq.push_back(model[exp_a[7:2]]);
        else model[exp_a[7:2]] = wq[beats];
        beats++;
      end
      if (done) begin
        dones++;
        errs = int'(error);
        if (bus_if.cyc) cyc_bad++;
      end
    end

    err_en = 1'b0; ack_en = 1'b1; wr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (rd_valid || done || wr_ready || bus_if.cyc) extra++;
    end
    for (int i = 0; i < 64; i++) if (ram[i] !== model[i]) diffs++;
    last_stb = stbc;

    check({tag, " beats"}, 32'(beats), 32'(exp_beats));
    check({tag, " rd_valid_count"}, 32'(rds), we ? 32'd0 : 32'(exp_beats));
    check({tag, " wr_ready_count"}, 32'(wrs), we ? 32'(exp_beats) : 32'd0);
    check({tag, " done_count"}, 32'(dones), 32'd1);
    check({tag, " error_flag"}, 32'(errs), 32'(exp_err));
    check({tag, " adr_seq"}, 32'(adr_bad), 32'd0);
    check({tag, " cti_seq"}, 32'(cti_bad), 32'd0);
    check({tag, " rd_data"}, 32'(rd_bad), 32'd0);
    check({tag, " stb_gating"}, 32'(gap_bad), 32'd0);
    check({tag, " cyc_low_at_done"}, 32'(cyc_bad), 32'd0);
    check({tag, " ready_in_burst"}, 32'(ready_bad), 32'd0);
    check({tag, " quiet_after"}, 32'(extra), 32'd0);
    check({tag, " ram_contents"}, 32'(diffs), 32'd0);
    check({tag, " ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int len, ga, gc, eb;
    int dcount;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; ack_en = 1'b1; err_en = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_dat = '0; last_rd = '0; last_stb = 0;
    #12;
    check("rst cyc", 32'(bus_if.cyc), 32'd0);
    check("rst stb", 32'(bus_if.stb), 32'd0);
    check("rst we", 32'(bus_if.we), 32'd0);
    check("rst adr", 32'(bus_if.adr), 32'd0);
    check("rst cti", 32'(bus_if.cti), 32'd0);
    check("rst sel", 32'(bus_if.sel), 32'hF);
    check("rst bte", 32'(bus_if.bte), 32'd0);
    check("rst rd_valid", 32'(rd_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int i = 0; i < 4; i++) preload(4 + i, 32'hA0 + 32'(i));

    run_cmd("rd4", 1'b0, 8'h10, 3, 0, 0, -1, 100);
    check("rd4 last_data", last_rd, 32'hA3);
    run_cmd("wr1", 1'b1, 8'h40, 0, 0, 0, -1, 100);
    run_cmd("wr1_readback_cmd", 1'b0, 8'h40, 0, 0, 0, -1, 100);
    check("wr1 readback", last_rd, model[16]);
    run_cmd("wr8_gap", 1'b1, 8'h80, 7, 2, 3, -1, 100);
    run_cmd("wr8_readback", 1'b0, 8'h80, 7, 0, 0, -1, 100);
    run_cmd("rd_wrap", 1'b0, 8'hF8, 2, 0, 0, -1, 100);
    run_cmd("rd_err", 1'b0, 8'h20, 3, 0, 0, 1, 100);
    run_cmd("rd_unaligned", 1'b0, 8'h33, 1, 0, 0, -1, 60);

    for (int k = 0; k < 24; k++) begin
      len = $urandom_range(0, 7);
      ga  = (len > 0) ? $urandom_range(1, len) : 0;
      gc  = $urandom_range(0, 3);
      eb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      run_cmd($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 8'($urandom), len, ga, gc, eb, 70);
    end

    // Reset in the middle of a stalled read burst.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h60; cmd_len = 3'd7; ack_en = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst cyc", 32'(bus_if.cyc), 32'd0);
    check("midrst stb", 32'(bus_if.stb), 32'd0);
    check("midrst cti", 32'(bus_if.cti), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; ack_en = 1'b1;
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done || rd_valid || bus_if.cyc) dcount++;
    end
    check("midrst no_done", 32'(dcount), 32'd0);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    run_cmd("timeout", 1'b0, 8'h00, 3, 0, 0, -1, 0);
    check("timeout stalled_cycles", 32'(last_stb), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
